// File: rtl/fe_wbuf_pkg.sv
// Shared types for the cache front-end: FSM state encoding, request classes and
// the default control-register address width.
package fe_wbuf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWack,
    StDrain,
    StRead,
    StCtrl
  } fe_state_e;

  typedef enum logic [1:0] {
    ReqDWrite,
    ReqDRead,
    ReqCtrl
  } fe_req_e;

  localparam int unsigned FeCtrlAddrWDefault = 4;

  function automatic fe_req_e fe_classify(input logic is_ctrl, input logic has_strb);
    if (is_ctrl) begin
      return ReqCtrl;
    end
    if (has_strb) begin
      return ReqDWrite;
    end
    return ReqDRead;
  endfunction

endpackage

// File: rtl/fe_wbuf_fifo.sv
// Posted-write buffer storage: synchronous FIFO with occupancy, full/empty flags
// and asynchronous active-high reset. A push into a full FIFO is taken only
// when a pop happens in the same cycle.
module fe_wbuf_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic [LvlW-1:0]  level,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LvlW'(Depth));
  assign empty   = (level_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/front_end_wbuf.sv
// Cache front-end with posted-write buffer, read/ctrl ordering behind buffered
// writes, and read watchpoints. Define FE_WP_COUNT_EN to build hit counters.
module front_end_wbuf
  import fe_wbuf_pkg::*;
#(
  parameter int unsigned FE_ADDR_W   = 32,
  parameter int unsigned FE_DATA_W   = 32,
  parameter int unsigned CTRL_CACHE  = 0,
  parameter int unsigned CTRL_ADDR_W = FeCtrlAddrWDefault,
  parameter int unsigned WBUF_DEPTH  = 4,
  parameter int unsigned NUM_WP      = 2,
  parameter int unsigned WP_CNT_W    = 8,
  localparam int unsigned FE_NBYTES  = FE_DATA_W / 8,
  localparam int unsigned FE_BYTE_W  = $clog2(FE_NBYTES),
  localparam int unsigned WADDR_W    = FE_ADDR_W - FE_BYTE_W,
  localparam int unsigned ADDR_IN_W  = CTRL_CACHE + FE_ADDR_W,
  localparam int unsigned LVL_W      = $clog2(WBUF_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid,
  input  logic [ADDR_IN_W-1:0]          addr,
  input  logic [FE_DATA_W-1:0]          wdata,
  input  logic [FE_NBYTES-1:0]          wstrb,
  output logic                          ready,
  output logic [FE_DATA_W-1:0]          rdata,
  output logic                          data_valid,
  output logic [WADDR_W-1:0]            data_addr,
  output logic [FE_DATA_W-1:0]          data_wdata,
  output logic [FE_NBYTES-1:0]          data_wstrb,
  input  logic [FE_DATA_W-1:0]          data_rdata,
  input  logic                          data_ready,
  output logic                          ctrl_valid,
  output logic [CTRL_ADDR_W-1:0]        ctrl_addr,
  input  logic [FE_DATA_W-1:0]          ctrl_rdata,
  input  logic                          ctrl_ready,
  input  logic [NUM_WP-1:0]             wp_en,
  input  logic [NUM_WP*WADDR_W-1:0]     wp_addr,
  input  logic [NUM_WP*FE_DATA_W-1:0]   wp_data,
  input  logic                          wp_clr,
  output logic [NUM_WP-1:0]             wp_hit,
  output logic [NUM_WP*WP_CNT_W-1:0]    wp_cnt,
  output logic [LVL_W-1:0]              wbuf_level
);

  localparam int unsigned ENTRY_W = WADDR_W + FE_DATA_W + FE_NBYTES;

  fe_state_e state_q, state_d;
  fe_req_e   req_class;
  logic      is_ctrl;

  logic [ENTRY_W-1:0] push_entry, head_entry;
  logic [WADDR_W-1:0] front_waddr;
  logic [LVL_W-1:0]   fifo_level;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty, can_push;
  logic [NUM_WP-1:0]  wp_match, wp_hit_q;
  logic               unused_addr_lsb;

  assign is_ctrl     = (CTRL_CACHE != 0) && addr[ADDR_IN_W-1];
  assign req_class   = fe_classify(is_ctrl, |wstrb);
  assign front_waddr = addr[FE_BYTE_W +: WADDR_W];
  assign ctrl_addr   = addr[FE_BYTE_W +: CTRL_ADDR_W];
  assign push_entry  = {front_waddr, wdata, wstrb};
  assign wbuf_level  = fifo_level;

  assign unused_addr_lsb = ^addr[FE_BYTE_W-1:0];

  // The buffer owns the cache port everywhere except READ.
  assign fifo_pop = data_ready && !fifo_empty && (state_q != StRead);
  assign can_push = !fifo_full || fifo_pop;

  fe_wbuf_fifo #(
    .Width(ENTRY_W),
    .Depth(WBUF_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .wdata(push_entry),
    .pop  (fifo_pop),
    .rdata(head_entry),
    .level(fifo_level),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fifo_push  = 1'b0;
    ready      = 1'b0;
    rdata      = '0;
    ctrl_valid = 1'b0;
    data_valid = !fifo_empty;
    data_addr  = head_entry[FE_DATA_W+FE_NBYTES +: WADDR_W];
    data_wdata = head_entry[FE_NBYTES +: FE_DATA_W];
    data_wstrb = head_entry[FE_NBYTES-1:0];

    unique case (state_q)
      StIdle: begin
        if (valid) begin
          case (req_class)
            ReqDWrite: begin
              if (can_push) begin
                fifo_push = 1'b1;
                state_d   = StWack;
              end
            end
            ReqCtrl: state_d = fifo_empty ? StCtrl : StDrain;
            default: state_d = fifo_empty ? StRead : StDrain;
          endcase
        end
      end
      StWack: begin
        ready   = 1'b1;
        state_d = StIdle;
      end
      StDrain: begin
        if (fifo_empty) begin
          state_d = (req_class == ReqCtrl) ? StCtrl : StRead;
        end
      end
      StRead: begin
        data_valid = 1'b1;
        data_addr  = front_waddr;
        data_wdata = '0;
        data_wstrb = '0;
        if (data_ready) begin
          ready   = 1'b1;
          rdata   = data_rdata;
          state_d = StIdle;
        end
      end
      StCtrl: begin
        ctrl_valid = 1'b1;
        if (ctrl_ready) begin
          ready   = 1'b1;
          rdata   = ctrl_rdata;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  for (genvar i = 0; i < NUM_WP; i++) begin : g_wp_match
    assign wp_match[i] = ready && (state_q == StRead) && wp_en[i] &&
                         (data_addr == wp_addr[i*WADDR_W +: WADDR_W]) &&
                         (data_rdata == wp_data[i*FE_DATA_W +: FE_DATA_W]);
  end

  // Clear wins over a match landing on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_hit_q <= '0;
    end else if (wp_clr) begin
      wp_hit_q <= '0;
    end else begin
      wp_hit_q <= wp_hit_q | wp_match;
    end
  end

  assign wp_hit = wp_hit_q;

`ifdef FE_WP_COUNT_EN
  for (genvar i = 0; i < NUM_WP; i++) begin : g_wp_cnt
    logic [WP_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (wp_clr) begin
        cnt_q <= '0;
      end else if (wp_match[i] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + WP_CNT_W'(1);
      end
    end

    assign wp_cnt[i*WP_CNT_W +: WP_CNT_W] = cnt_q;
  end
`else
  assign wp_cnt = '0;
`endif

endmodule

// File: tb/tb_front_end_wbuf.sv
// Directed bench for front_end_wbuf with write/read scoreboards and a simple
// cache/control responder model.
module tb_front_end_wbuf;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned WAW = 30;
  localparam int unsigned CW = 2;
`ifdef FE_WP_COUNT_EN
  localparam int CntOn = 1;
`else
  localparam int CntOn = 0;
`endif

  typedef struct packed {
    logic [WAW-1:0] waddr;
    logic [DW-1:0]  wdata;
    logic [3:0]     wstrb;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid;
  logic [AW:0]     addr;
  logic [DW-1:0]   wdata;
  logic [3:0]      wstrb;
  logic            ready;
  logic [DW-1:0]   rdata;
  logic            data_valid;
  logic [WAW-1:0]  data_addr;
  logic [DW-1:0]   data_wdata;
  logic [3:0]      data_wstrb;
  logic [DW-1:0]   data_rdata;
  logic            data_ready;
  logic            ctrl_valid;
  logic [3:0]      ctrl_addr;
  logic [DW-1:0]   ctrl_rdata;
  logic            ctrl_ready;
  logic [1:0]      wp_en;
  logic [2*WAW-1:0] wp_addr;
  logic [2*DW-1:0] wp_data;
  logic            wp_clr;
  logic [1:0]      wp_hit;
  logic [2*CW-1:0] wp_cnt;
  logic [2:0]      wbuf_level;

  logic cache_go, ctrl_go;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;
  logic [DW-1:0] rd_obs;
  wr_t  wq[$];
  logic [DW-1:0] rq[$];

  assign data_ready = cache_go & data_valid;
  assign ctrl_ready = ctrl_go & ctrl_valid;

  always #5 clk = ~clk;

  front_end_wbuf #(
    .FE_ADDR_W  (AW),
    .FE_DATA_W  (DW),
    .CTRL_CACHE (1),
    .CTRL_ADDR_W(4),
    .WBUF_DEPTH (4),
    .NUM_WP     (2),
    .WP_CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid),
    .addr      (addr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .ready     (ready),
    .rdata     (rdata),
    .data_valid(data_valid),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_wstrb(data_wstrb),
    .data_rdata(data_rdata),
    .data_ready(data_ready),
    .ctrl_valid(ctrl_valid),
    .ctrl_addr (ctrl_addr),
    .ctrl_rdata(ctrl_rdata),
    .ctrl_ready(ctrl_ready),
    .wp_en     (wp_en),
    .wp_addr   (wp_addr),
    .wp_data   (wp_data),
    .wp_clr    (wp_clr),
    .wp_hit    (wp_hit),
    .wp_cnt    (wp_cnt),
    .wbuf_level(wbuf_level)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; holds the request until ready, returns at posedge+1.
  task automatic front_req(input logic [AW:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           input int budget);
    valid = 1'b1;
    addr  = a;
    wdata = d;
    wstrb = s;
    lat   = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (ready) begin
        lat    = c;
        rd_obs = rdata;
        break;
      end
    end
    step();
    valid = 1'b0;
    wstrb = 4'h0;
  endtask

  task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] s);
    wr_t e;
    e.waddr = a[AW-1:2];
    e.wdata = d;
    e.wstrb = s;
    wq.push_back(e);
    front_req({1'b0, a}, d, s, 8);
    chk({tag, "_lat"}, 64'(lat), 64'd2);
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rq.push_back(exp);
    data_rdata = exp;
    front_req({1'b0, a}, '0, 4'h0, 12);
    chk({tag, "_done"}, 64'(lat > 0), 64'd1);
    if (rq.size() != 0) begin
      chk({tag, "_rdata"}, 64'(rd_obs), 64'(rq[0]));
      rq.delete(0);
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int c = 0; c < 30 && wq.size() != 0; c++) @(posedge clk);
    #1;
    chk(tag, 64'(wq.size()), 64'd0);
    @(negedge clk);
    chk({tag, "_level"}, 64'(wbuf_level), 64'd0);
    step();
  endtask

  // Cache-side write scoreboard.
  always @(negedge clk) begin
    if (!reset && data_valid && data_ready && (data_wstrb != 4'h0)) begin
      chk("wq_nonempty", 64'(wq.size() != 0), 64'd1);
      if (wq.size() != 0) begin
        chk("wr_addr", 64'(data_addr), 64'(wq[0].waddr));
        chk("wr_data", 64'(data_wdata), 64'(wq[0].wdata));
        chk("wr_strb", 64'(data_wstrb), 64'(wq[0].wstrb));
        wq.delete(0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    logic [WAW-1:0] obs_addr;
    reset = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    data_rdata = '0; ctrl_rdata = '0; cache_go = 1'b0; ctrl_go = 1'b0;
    wp_en = '0; wp_addr = '0; wp_data = '0; wp_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_dvalid", 64'(data_valid), 64'd0);
    chk("rst_cvalid", 64'(ctrl_valid), 64'd0);
    chk("rst_hit", 64'(wp_hit), 64'd0);
    chk("rst_cnt", 64'(wp_cnt), 64'd0);
    chk("rst_level", 64'(wbuf_level), 64'd0);
    step();
    reset = 1'b0;
    step();

    // Single posted write, then let the cache take it.
    do_write("t1_wr", 32'h1000, 32'h11223344, 4'hF);
    @(negedge clk);
    chk("t1_ready_pulse", 64'(ready), 64'd0);
    chk("t1_level1", 64'(wbuf_level), 64'd1);
    chk("t1_head_valid", 64'(data_valid), 64'd1);
    step();
    cache_go = 1'b1;
    wait_drain("t1_drain");
    cache_go = 1'b0;

    // Fill the buffer, stall the fifth write, release with one pop.
    for (int i = 0; i < 4; i++) begin
      do_write("t2_fill", 32'h400 + 32'(4 * i), 32'hA0 + 32'(i), (i == 1) ? 4'h3 : 4'hF);
    end
    @(negedge clk);
    chk("t2_level_full", 64'(wbuf_level), 64'd4);
    step();
    begin
      wr_t e;
      e.waddr = 30'h104; e.wdata = 32'hA4; e.wstrb = 4'hF;
      wq.push_back(e);
    end
    valid = 1'b1; addr = {1'b0, 32'h410}; wdata = 32'hA4; wstrb = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t2_stall_ready", 64'(ready), 64'd0);
      chk("t2_stall_level", 64'(wbuf_level), 64'd4);
    end
    step();
    cache_go = 1'b1;
    step();
    cache_go = 1'b0;
    @(negedge clk);
    chk("t2_fifth_ack", 64'(ready), 64'd1);
    chk("t2_level_kept", 64'(wbuf_level), 64'd4);
    step();
    valid = 1'b0; wstrb = 4'h0;
    cache_go = 1'b1;
    wait_drain("t2_drain");
    cache_go = 1'b0;

    // Read must wait behind buffered writes.
    do_write("t3_wr0", 32'h3000, 32'h5, 4'hF);
    do_write("t3_wr1", 32'h3004, 32'h6, 4'hF);
    rq.push_back(32'hCAFEEFAC);
    data_rdata = 32'hCAFEEFAC;
    valid = 1'b1; addr = {1'b0, 32'h2000}; wstrb = 4'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_no_early_read", 64'(data_valid && data_wstrb == 4'h0), 64'd0);
      chk("t3_no_early_ready", 64'(ready), 64'd0);
    end
    step();
    cache_go = 1'b1;
    got = 0;
    obs_addr = '0;
    for (int c = 0; c < 12 && got == 0; c++) begin
      @(negedge clk);
      chk("t3_order", 64'(data_valid && data_wstrb == 4'h0 && wbuf_level != 3'd0), 64'd0);
      if (ready) begin
        got = 1;
        rd_obs = rdata;
        obs_addr = data_addr;
      end
    end
    chk("t3_read_done", 64'(got), 64'd1);
    chk("t3_rdata", 64'(rd_obs), 64'(rq[0]));
    rq.delete(0);
    chk("t3_raddr", 64'(obs_addr), 64'h800);
    step();
    valid = 1'b0; cache_go = 1'b0;
    chk("t3_writes_out", 64'(wq.size()), 64'd0);

    // Control-space read.
    ctrl_rdata = 32'h7;
    valid = 1'b1; addr = {1'b1, 32'h0000000C}; wstrb = 4'h0;
    @(posedge clk);
    @(negedge clk);
    chk("t4_cvalid", 64'(ctrl_valid), 64'd1);
    chk("t4_caddr", 64'(ctrl_addr), 64'd3);
    chk("t4_dvalid", 64'(data_valid), 64'd0);
    chk("t4_wait", 64'(ready), 64'd0);
    step();
    ctrl_go = 1'b1;
    @(negedge clk);
    chk("t4_ready", 64'(ready), 64'd1);
    chk("t4_rdata", 64'(rdata), 64'h7);
    chk("t4_dvalid2", 64'(data_valid), 64'd0);
    step();
    ctrl_go = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("t4_cvalid_off", 64'(ctrl_valid), 64'd0);
    step();

    // Watchpoints: channel 1 programmed identically but disabled.
    wp_en = 2'b01;
    wp_addr = {30'h48D, 30'h48D};
    wp_data = {32'hDEADBEEF, 32'hDEADBEEF};
    cache_go = 1'b1;
    data_rdata = 32'hDEADBEEF;
    do_write("t5_wr", 32'h1234, 32'hDEADBEEF, 4'hF);
    wait_drain("t5_drain");
    chk("t5_wr_nohit", 64'(wp_hit), 64'd0);
    do_read("t5_other", 32'h1238, 32'hDEADBEEF);
    chk("t5_addr_nohit", 64'(wp_hit), 64'd0);
    do_read("t5_data", 32'h1234, 32'h0BADF00D);
    chk("t5_data_nohit", 64'(wp_hit), 64'd0);
    for (int i = 0; i < 3; i++) do_read("t5_m", 32'h1234, 32'hDEADBEEF);
    chk("t5_hit", 64'(wp_hit), 64'd1);
    chk("t5_cnt0", 64'(wp_cnt[CW-1:0]), (CntOn != 0) ? 64'd3 : 64'd0);
    chk("t5_cnt1", 64'(wp_cnt[2*CW-1:CW]), 64'd0);
    wp_clr = 1'b1;
    do_read("t5_clr", 32'h1234, 32'hDEADBEEF);
    wp_clr = 1'b0;
    chk("t5_clr_hit", 64'(wp_hit), 64'd0);
    chk("t5_clr_cnt", 64'(wp_cnt), 64'd0);
    for (int i = 0; i < 5; i++) do_read("t5_sat", 32'h1234, 32'hDEADBEEF);
    chk("t5_sat_hit", 64'(wp_hit), 64'd1);
    chk("t5_sat_cnt", 64'(wp_cnt[CW-1:0]), (CntOn != 0) ? 64'd3 : 64'd0);
    cache_go = 1'b0;
    wp_en = 2'b00;

    // Reset while draining discards everything.
    for (int i = 0; i < 3; i++) do_write("t6_wr", 32'h5000 + 32'(4 * i), 32'h60 + 32'(i), 4'hF);
    valid = 1'b1; addr = {1'b0, 32'h2000}; wstrb = 4'h0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_level3", 64'(wbuf_level), 64'd3);
    step();
    reset = 1'b1;
    #1;
    chk("t6_rst_level", 64'(wbuf_level), 64'd0);
    chk("t6_rst_dvalid", 64'(data_valid), 64'd0);
    chk("t6_rst_ready", 64'(ready), 64'd0);
    wq.delete();
    valid = 1'b0;
    step();
    reset = 1'b0;
    cache_go = 1'b1;
    do_read("t6_fresh", 32'h2000, 32'hCAFEEFAC);
    chk("t6_fresh_lat", 64'(lat), 64'd2);
    cache_go = 1'b0;
    @(negedge clk);
    chk("t6_idle_dvalid", 64'(data_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/front_end_wbuf.md
Name: front_end_wbuf

Overview:
Next-generation cache front-end. Sits between the CPU-side native valid/ready port and the cache data path and cache-control block. Adds a parametrised posted-write buffer with read/ctrl ordering, and NUM_WP runtime-programmable read watchpoints with sticky hit flags and saturating hit counters.

Parameters:
- FE_ADDR_W, 32, byte-address width of cache space.
- FE_DATA_W, 32, word width; FE_NBYTES = FE_DATA_W/8 and FE_BYTE_W = $clog2(FE_NBYTES) are derived.
- CTRL_CACHE, 0, 1 = address MSB selects cache-control space.
- CTRL_ADDR_W, 4, control register address width.
- WBUF_DEPTH, 4, write-buffer entries; power of 2, ≥2.
- NUM_WP, 2, number of watchpoint channels, ≥1.
- WP_CNT_W, 8, per-channel hit counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid  in  1  front request; held until ready
- addr  in  CTRL_CACHE+FE_ADDR_W  byte address; MSB = ctrl select when CTRL_CACHE=1
- wdata  in  FE_DATA_W  write data
- wstrb  in  FE_NBYTES  byte enables; 0 = read
- ready  out  1  request completion, one-cycle pulse
- rdata  out  FE_DATA_W  read data, valid while ready=1
- data_valid  out  1  cache data request
- data_addr  out  FE_ADDR_W-FE_BYTE_W  word address
- data_wdata  out  FE_DATA_W  write data to cache
- data_wstrb  out  FE_NBYTES  byte enables to cache
- data_rdata  in  FE_DATA_W  cache read data
- data_ready  in  1  cache completion
- ctrl_valid  out  1  control request
- ctrl_addr  out  CTRL_ADDR_W  addr[FE_BYTE_W +: CTRL_ADDR_W]
- ctrl_rdata  in  FE_DATA_W  control read data
- ctrl_ready  in  1  control completion
- wp_en  in  NUM_WP  per-channel enable
- wp_addr  in  NUM_WP*(FE_ADDR_W-FE_BYTE_W)  flattened match word addresses; channel i at slice i
- wp_data  in  NUM_WP*FE_DATA_W  flattened match data
- wp_clr  in  1  clears all hits and counters
- wp_hit  out  NUM_WP  sticky hit flags
- wp_cnt  out  NUM_WP*WP_CNT_W  flattened hit counters
- wbuf_level  out  $clog2(WBUF_DEPTH)+1  buffer occupancy

Behaviour:
- Reset values: ready=0, data_valid=0, ctrl_valid=0, wp_hit=0, wp_cnt=0, wbuf_level=0; FSM in IDLE. Reset mid-operation discards all buffered writes and any in-flight request.
- Request classes:
  - ctrl = CTRL_CACHE && addr MSB.
  - dwrite = !ctrl && wstrb≠0.
  - dread = !ctrl && wstrb==0.
- FSM states and transitions:
  - IDLE, dwrite, buffer not full: push {word addr, wdata, wstrb}; go to WACK.
  - IDLE, dwrite, buffer full: stay in IDLE (stall) until a pop frees an entry.
  - IDLE, dread or ctrl, buffer empty: go to READ or CTRL respectively.
  - IDLE, dread or ctrl, buffer not empty: go to DRAIN.
  - WACK: ready=1 for exactly one cycle; go to IDLE. Max posted-write rate is 1 per 2 cycles; write latency is 1 cycle after acceptance.
  - DRAIN: wait until wbuf_level==0, then go to READ or CTRL.
  - READ: data_valid=1, data_addr = front addr, data_wstrb=0. On data_ready: ready=1 and rdata=data_rdata in the same cycle (combinational); go to IDLE.
  - CTRL: ctrl_valid=1. On ctrl_ready: ready=1 and rdata=ctrl_rdata; go to IDLE.
- Cache-side arbitration:
  - Outside READ, the buffer head drives data_valid/addr/wdata/wstrb whenever the buffer is not empty.
  - Pop on data_ready.
  - Push and pop in the same cycle: level unchanged, pointers both advance, wrap modulo WBUF_DEPTH.
  - Pop never occurs in READ.
- Watchpoints:
  - Channel i matches in any cycle with ready=1, state READ, wp_en[i]=1, data_addr==wp_addr[i] and data_rdata==wp_data[i].
  - On a match, wp_hit[i] sets on the next edge and wp_cnt[i] increments on the next edge, saturating at 2^WP_CNT_W−1.
  - wp_clr takes priority over a simultaneous match: the result is 0.
  - Writes and ctrl reads never match.

Optional Feature:
- FE_WP_COUNT_EN
  - Defined: per-channel saturating counters are present as described.
  - Undefined: counters are not instantiated, wp_cnt is tied to 0, and wp_hit behaviour is unchanged.

Decomposition:
- Package fe_wbuf_pkg: FSM state encoding (IDLE, WACK, DRAIN, READ, CTRL), request-class codes, default CTRL_ADDR_W.
- One sub-module, fe_wbuf_fifo: synchronous FIFO of width (FE_ADDR_W-FE_BYTE_W)+FE_DATA_W+FE_NBYTES with push/pop/level/full/empty and asynchronous reset.

Test Plan:
- Write 0x11223344 to 0x1000, wstrb=F: ready pulses 1 cycle later; cache later sees data_addr=0x400, data_wdata=0x11223344; wbuf_level goes 1→0.
- 5 back-to-back writes with data_ready=0, WBUF_DEPTH=4: 4 acked, 5th stalls with ready=0; first data_ready pop lets the 5th be acked; level stays 4.
- 2 buffered writes then a read of 0x2000: no read data_valid until level=0; then READ, and data_rdata=0xCAFEEFAC returns ready=1, rdata=0xCAFEEFAC.
- CTRL_CACHE=1, read with addr MSB=1, addr[5:2]=3: ctrl_valid=1, ctrl_addr=3; ctrl_ready with ctrl_rdata=0x7 gives rdata=0x7; data_valid remains 0.
- wp_en=01, wp_addr0=0x48D, wp_data0=0xDEADBEEF; three matching reads gives wp_hit=01, wp_cnt0=3; wp_clr asserted together with a 4th match gives 0; with WP_CNT_W=2 and 5 matches, counter holds 3.
- Reset asserted in DRAIN with 3 buffered writes: level=0, data_valid=0, ready=0 immediately; after release, a fresh read goes directly to READ.
